// File: rtl/mdio_apb_arbiter_if.sv
// Bundle for two APB requesters and the shared APB slave (apbmapper) behind the arbiter.
// master: arbiter side; slave: requesters and slave model side.
interface mdio_apb_arbiter_if;
  logic [31:0] m0_paddr;
  logic        m0_pwrite;
  logic        m0_psel;
  logic        m0_penable;
  logic [15:0] m0_pwdata;
  logic        m0_pready;
  logic [15:0] m0_prdata;
  logic        m0_pslverr;

  logic [31:0] m1_paddr;
  logic        m1_pwrite;
  logic        m1_psel;
  logic        m1_penable;
  logic [15:0] m1_pwdata;
  logic        m1_pready;
  logic [15:0] m1_prdata;
  logic        m1_pslverr;

  logic [31:0] s_paddr;
  logic        s_pwrite;
  logic        s_psel;
  logic        s_penable;
  logic [15:0] s_pwdata;
  logic        s_pready;
  logic [15:0] s_prdata;
  logic        s_pslverr;

  logic [1:0]  arb_owner;

  modport master (
    input  m0_paddr, m0_pwrite, m0_psel, m0_penable, m0_pwdata,
    output m0_pready, m0_prdata, m0_pslverr,
    input  m1_paddr, m1_pwrite, m1_psel, m1_penable, m1_pwdata,
    output m1_pready, m1_prdata, m1_pslverr,
    output s_paddr, s_pwrite, s_psel, s_penable, s_pwdata,
    input  s_pready, s_prdata, s_pslverr,
    output arb_owner
  );

  modport slave (
    output m0_paddr, m0_pwrite, m0_psel, m0_penable, m0_pwdata,
    input  m0_pready, m0_prdata, m0_pslverr,
    output m1_paddr, m1_pwrite, m1_psel, m1_penable, m1_pwdata,
    input  m1_pready, m1_prdata, m1_pslverr,
    input  s_paddr, s_pwrite, s_psel, s_penable, s_pwdata,
    output s_pready, s_prdata, s_pslverr,
    input  arb_owner
  );
endinterface

// File: rtl/mdio_apb_arbiter.sv
// Round-robin arbiter letting two APB requesters share one APB slave (MDIO register mapper).
// Define MDIO_APB_ARB_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES without s_pready.
module mdio_apb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                rst,
  mdio_apb_arbiter_if.master apb_io
);

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StSetup  = 4'b0010,
    StAccess = 4'b0100,
    StResp   = 4'b1000
  } state_e;

  state_e      state_q;
  logic        last_m1_q;
  logic [1:0]  owner_q;
  logic [31:0] paddr_q;
  logic        pwrite_q;
  logic [15:0] pwdata_q;
  logic        psel_q;
  logic        penable_q;
  logic [1:0]  pready_q;
  logic [1:0]  pslverr_q;
  logic [15:0] m0_prdata_q;
  logic [15:0] m1_prdata_q;

  logic        grant_m1;
  logic        done;
  logic        rsp_err;
  logic [15:0] rsp_rdata;

`ifdef MDIO_APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // PENABLE from requesters carries no arbitration information.
  logic unused_penable;
  assign unused_penable = apb_io.m0_penable ^ apb_io.m1_penable;

  always_comb begin
    // m1 wins only if alone or if m0 was the previous grantee.
    grant_m1  = apb_io.m1_psel && (!apb_io.m0_psel || !last_m1_q);
    done      = (state_q == StAccess) && apb_io.s_pready;
    rsp_rdata = apb_io.s_prdata;
    rsp_err   = apb_io.s_pslverr;
`ifdef MDIO_APB_ARB_TIMEOUT_EN
    if ((state_q == StAccess) && !apb_io.s_pready && (cnt_q == TimeoutLast)) begin
      done      = 1'b1;
      rsp_rdata = 16'hFFFF;
      rsp_err   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_m1_q   <= 1'b1;
      owner_q     <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pready_q    <= '0;
      pslverr_q   <= '0;
      m0_prdata_q <= '0;
      m1_prdata_q <= '0;
`ifdef MDIO_APB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (apb_io.m0_psel || apb_io.m1_psel) begin
            state_q   <= StSetup;
            last_m1_q <= grant_m1;
            owner_q   <= grant_m1 ? 2'b10 : 2'b01;
            psel_q    <= 1'b1;
            paddr_q   <= grant_m1 ? apb_io.m1_paddr : apb_io.m0_paddr;
            pwrite_q  <= grant_m1 ? apb_io.m1_pwrite : apb_io.m0_pwrite;
            pwdata_q  <= grant_m1 ? apb_io.m1_pwdata : apb_io.m0_pwdata;
`ifdef MDIO_APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (done) begin
            state_q   <= StResp;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pready_q  <= owner_q;
            pslverr_q <= owner_q & {2{rsp_err}};
            if (owner_q[0]) m0_prdata_q <= rsp_rdata;
            if (owner_q[1]) m1_prdata_q <= rsp_rdata;
          end
`ifdef MDIO_APB_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        StResp: begin
          state_q     <= StIdle;
          owner_q     <= '0;
          pready_q    <= '0;
          pslverr_q   <= '0;
          m0_prdata_q <= '0;
          m1_prdata_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign apb_io.s_paddr    = paddr_q;
  assign apb_io.s_pwrite   = pwrite_q;
  assign apb_io.s_pwdata   = pwdata_q;
  assign apb_io.s_psel     = psel_q;
  assign apb_io.s_penable  = penable_q;
  assign apb_io.arb_owner  = owner_q;
  assign apb_io.m0_pready  = pready_q[0];
  assign apb_io.m1_pready  = pready_q[1];
  assign apb_io.m0_pslverr = pslverr_q[0];
  assign apb_io.m1_pslverr = pslverr_q[1];
  assign apb_io.m0_prdata  = m0_prdata_q;
  assign apb_io.m1_prdata  = m1_prdata_q;

endmodule

// File: tb/tb_mdio_apb_arbiter.sv
// Directed self-checking bench for mdio_apb_arbiter; inputs driven and outputs sampled on negedge.
module tb_mdio_apb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mdio_apb_arbiter_if bus ();

  mdio_apb_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .apb_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit m, input logic sel, input logic wr,
                           input logic [31:0] addr, input logic [15:0] wdata);
    if (m) begin
      bus.m1_psel    = sel;
      bus.m1_penable = sel;
      bus.m1_pwrite  = wr;
      bus.m1_paddr   = addr;
      bus.m1_pwdata  = wdata;
    end else begin
      bus.m0_psel    = sel;
      bus.m0_penable = sel;
      bus.m0_pwrite  = wr;
      bus.m0_paddr   = addr;
      bus.m0_pwdata  = wdata;
    end
  endtask

  // One complete transfer by requester m; slave answers in ACCESS cycle n_access.
  task automatic run_xfer(input bit m, input logic wr, input logic [31:0] addr,
                          input logic [15:0] wdata, input int n_access,
                          input logic [15:0] rdata, input logic err, input bit keep);
    logic [1:0] own;
    own = m ? 2'b10 : 2'b01;
    drive_req(m, 1'b1, wr, addr, wdata);
    tick();
    check("setup_sel", {30'd0, bus.s_psel, bus.s_penable}, 32'd2);
    check("setup_owner", {30'd0, bus.arb_owner}, {30'd0, own});
    check("setup_addr", bus.s_paddr, addr);
    check("setup_ctl", {15'd0, bus.s_pwrite, bus.s_pwdata}, {15'd0, wr, wdata});
    drive_req(m, 1'b1, ~wr, ~addr, ~wdata);
    tick();
    for (int i = 0; i < n_access; i++) begin
      check("access_sel", {30'd0, bus.s_psel, bus.s_penable}, 32'd3);
      check("access_addr", bus.s_paddr, addr);
      check("access_ctl", {15'd0, bus.s_pwrite, bus.s_pwdata}, {15'd0, wr, wdata});
      check("access_noready", {30'd0, bus.m1_pready, bus.m0_pready}, 32'd0);
      if (i == n_access - 1) begin
        bus.s_pready  = 1'b1;
        bus.s_prdata  = rdata;
        bus.s_pslverr = err;
      end
      tick();
    end
    bus.s_pready  = 1'b0;
    bus.s_prdata  = 16'h0;
    bus.s_pslverr = 1'b0;
    check("resp_ready", {30'd0, bus.m1_pready, bus.m0_pready}, {30'd0, own});
    check("resp_rdata", {bus.m1_prdata, bus.m0_prdata}, m ? {rdata, 16'h0} : {16'h0, rdata});
    check("resp_err", {30'd0, bus.m1_pslverr, bus.m0_pslverr}, {30'd0, err ? own : 2'b00});
    check("resp_bus", {30'd0, bus.s_psel, bus.s_penable}, 32'd0);
    check("resp_addr", bus.s_paddr, 32'd0);
    if (keep) drive_req(m, 1'b1, wr, addr, wdata);
    else drive_req(m, 1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    check("idle_owner", {30'd0, bus.arb_owner}, 32'd0);
    check("idle_ready", {30'd0, bus.m1_pready, bus.m0_pready}, 32'd0);
    check("idle_bus", {30'd0, bus.s_psel, bus.s_penable}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    drive_req(1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    bus.s_pready  = 1'b0;
    bus.s_prdata  = 16'h0;
    bus.s_pslverr = 1'b0;
    repeat (2) tick();

    check("rst_owner", {30'd0, bus.arb_owner}, 32'd0);
    check("rst_bus", {30'd0, bus.s_psel, bus.s_penable}, 32'd0);
    check("rst_addr", bus.s_paddr, 32'd0);
    check("rst_ready", {30'd0, bus.m1_pready, bus.m0_pready}, 32'd0);
    rst = 1'b0;
    tick();

    // Single write, read, slave error.
    run_xfer(1'b0, 1'b1, 32'h0001_0020, 16'hA5A5, 2, 16'h0000, 1'b0, 1'b0);
    run_xfer(1'b1, 1'b0, 32'h0001_0004, 16'h0000, 1, 16'h1234, 1'b0, 1'b0);
    run_xfer(1'b0, 1'b0, 32'h0001_0008, 16'h0000, 1, 16'hBEEF, 1'b1, 1'b0);

    // Reset in the middle of an m1 ACCESS.
    drive_req(1'b1, 1'b1, 1'b0, 32'h0001_0010, 16'h0000);
    tick();
    check("rmid_owner", {30'd0, bus.arb_owner}, 32'd2);
    tick();
    check("rmid_access", {30'd0, bus.s_psel, bus.s_penable}, 32'd3);
    rst = 1'b1;
    drive_req(1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    rst = 1'b0;
    check("rmid_bus", {30'd0, bus.s_psel, bus.s_penable}, 32'd0);
    check("rmid_addr", bus.s_paddr, 32'd0);
    check("rmid_owner0", {30'd0, bus.arb_owner}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rmid_noready", {30'd0, bus.m1_pready, bus.m0_pready}, 32'd0);
      tick();
    end
    run_xfer(1'b1, 1'b0, 32'h0001_0010, 16'h0000, 1, 16'h5A5A, 1'b0, 1'b0);

    // Contention from reset: pointer favours m0 first, then strict alternation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_req(1'b1, 1'b1, 1'b1, 32'h0001_0100, 16'h1111);
    run_xfer(1'b0, 1'b1, 32'h0001_0200, 16'h2222, 1, 16'h0000, 1'b0, 1'b1);
    run_xfer(1'b1, 1'b1, 32'h0001_0100, 16'h1111, 1, 16'h0000, 1'b0, 1'b1);
    run_xfer(1'b0, 1'b0, 32'h0001_0204, 16'h0000, 2, 16'h3333, 1'b0, 1'b1);
    run_xfer(1'b1, 1'b0, 32'h0001_0104, 16'h0000, 1, 16'h4444, 1'b0, 1'b1);
    run_xfer(1'b0, 1'b1, 32'h0001_0208, 16'h5555, 1, 16'h0000, 1'b0, 1'b0);
    run_xfer(1'b1, 1'b1, 32'h0001_0108, 16'h6666, 1, 16'h0000, 1'b0, 1'b0);

`ifdef MDIO_APB_ARB_TIMEOUT_EN
    // Slave never answers: abort after 8 ACCESS cycles.
    drive_req(1'b0, 1'b1, 1'b0, 32'h0001_0030, 16'h0000);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_wait", {30'd0, bus.s_psel, bus.s_penable}, 32'd3);
      check("to_noready", {30'd0, bus.m1_pready, bus.m0_pready}, 32'd0);
      tick();
    end
    check("to_ready", {30'd0, bus.m1_pready, bus.m0_pready}, 32'd1);
    check("to_rdata", {bus.m1_prdata, bus.m0_prdata}, 32'h0000_FFFF);
    check("to_err", {30'd0, bus.m1_pslverr, bus.m0_pslverr}, 32'd1);
    drive_req(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    check("to_idle", {29'd0, bus.s_psel, bus.arb_owner}, 32'd0);
    // s_pready in the final allowed cycle beats the timeout.
    run_xfer(1'b0, 1'b0, 32'h0001_0034, 16'h0000, 8, 16'h0042, 1'b0, 1'b0);
`else
    // Without the timeout the ACCESS phase simply waits.
    run_xfer(1'b0, 1'b0, 32'h0001_0034, 16'h0000, 20, 16'h0042, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdio_apb_arbiter.md
MDIO_APB_ARBITER -- requirements
Module: mdio_apb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, ACCESS cycles without s_pready before abort; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mN_paddr  input  32  requester N address (N = 0,1; same for all mN_ ports).
REQ-005 mN_pwrite  input  1  requester N direction, 1 = write.
REQ-006 mN_psel  input  1  requester N request; held high until mN_pready.
REQ-007 mN_penable  input  1  requester N APB enable; ignored for arbitration.
REQ-008 mN_pwdata  input  16  requester N write data.
REQ-009 mN_pready  output  1  requester N completion pulse.
REQ-010 mN_prdata  output  16  requester N read data; valid only with mN_pready.
REQ-011 mN_pslverr  output  1  requester N error; valid only with mN_pready.
REQ-012 s_paddr, s_pwrite, s_psel, s_penable, s_pwdata  output  32/1/1/1/16  shared APB slave (apbmapper) bus.
REQ-013 s_pready, s_prdata, s_pslverr  input  1/16/1  shared slave response.
REQ-014 arb_owner  output  2  one-hot current owner {m1,m0}; 2'b00 when idle.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS, RESP; one-hot encoded.
REQ-016 IDLE: if any mN_psel high, grant one, latch its paddr/pwrite/pwdata into holding registers, set arb_owner, go SETUP; else stay.
REQ-017 Arbitration round-robin: when both request in IDLE, grant the requester not granted last; single requester always granted.
REQ-018 Last-grant pointer updates only on grant; after reset it points to m1, so m0 wins first contention.
REQ-019 SETUP (exactly 1 cycle): s_psel=1, s_penable=0, s_paddr/s_pwrite/s_pwdata from holding registers; go ACCESS.
REQ-020 ACCESS: s_psel=1, s_penable=1, address/data held stable; on s_pready=1 capture s_prdata and s_pslverr, go RESP.
REQ-021 RESP (exactly 1 cycle): owner's mN_pready=1 with captured mN_prdata/mN_pslverr; s_psel=s_penable=0; go IDLE, arb_owner cleared.
REQ-022 Non-owner mN_pready/mN_prdata/mN_pslverr remain 0 at all times; a non-owner request waits with no timeout.
REQ-023 Outside SETUP/ACCESS, all s_ outputs are 0.
REQ-024 Latency: grant to mN_pready = 3 cycles + ACCESS wait cycles; minimum 4 cycles from mN_psel rise (IDLE sample) to mN_pready.
REQ-025 Requester changing mN_paddr/pwdata after grant has no effect on the in-flight transfer.
REQ-026 Requester dropping mN_psel mid-transfer does not abort; RESP still issued.
REQ-027 Back-to-back: requester still high in RESP is not re-granted until IDLE samples it; IDLE grants no earlier than cycle after RESP.

Reset
REQ-028 rst=1 at any clock edge forces IDLE, pointer to m1, holding/capture registers to 0, all outputs 0, timeout counter to 0.
REQ-029 rst mid-transfer abandons it without issuing mN_pready; slave bus drops to 0 the next cycle.

Configuration
REQ-030 Macro MDIO_APB_ARB_TIMEOUT_EN defined: 16-bit counter clears on SETUP entry, increments each ACCESS cycle without s_pready.
REQ-031 With macro: when counter reaches TIMEOUT_CYCLES in ACCESS without s_pready, go RESP with mN_prdata=16'hFFFF, mN_pslverr=1; s_pready arriving the same cycle wins (normal completion).
REQ-032 Without macro: no counter; ACCESS waits indefinitely for s_pready.

Verification
REQ-033 Single write: m0 writes 0x0001_0020 data 0xA5A5, s_pready after 2 ACCESS cycles -> slave sees same addr/data, pwrite=1; m0_pready pulse 1 cycle, pslverr=0.
REQ-034 Read: m1 reads 0x0001_0004, slave returns 0x1234 -> m1_prdata=0x1234 with m1_pready; m0 outputs stay 0.
REQ-035 Contention: m0 and m1 both assert from reset, each repeating 3 transfers -> grant order m0,m1,m0,m1,m0,m1.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=8): s_pready held 0 -> after 8 ACCESS cycles m0_pready=1, prdata=0xFFFF, pslverr=1; state returns IDLE.
REQ-037 Reset mid-ACCESS: assert rst one cycle during m1 transfer -> all outputs 0 next cycle, no m1_pready; subsequent m1 request completes normally.
REQ-038 Slave error: s_pslverr=1 with s_pready -> owner receives pslverr=1 and slave prdata unchanged.
